fibonacci_req_ctrl: RTL and testbench

Request-side controller for the `fibonacci_st` engine. It accepts term requests from a host over a valid/ready handshake and drives the engine's `start`/`term` inputs. It waits for `output_interface.valid`, then captures the engine's result into a small response FIFO that the host drains over a second valid/ready handshake. It sits between host logic and `fibonacci_st`, and gives the engine the one-request-at-a-time discipline it needs.

---
 rtl/fibonacci_pkg.sv | 26 ++
 rtl/fibonacci_rsp_fifo.sv | 53 +++++
 rtl/fibonacci_req_ctrl.sv | 144 ++++++++++++++
 tb/tb_fibonacci_req_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fibonacci_pkg.sv
// Shared types for the fibonacci engine and its request-side controller.
// FIB_LUT backs the optional result checker (FIB_CHECK_EN).
package fibonacci_pkg;

    typedef struct packed {
        logic       valid;
        logic [7:0] result;
    } t_output_interface;

    typedef struct packed {
        logic       timeout;
        logic       mismatch;
        logic [2:0] term;
        logic [7:0] result;
    } t_fib_rsp;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } t_fib_req_state;

    // F(0)=0, F(1)=1
    localparam logic [7:0] FIB_LUT [0:7] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13};

endpackage

// File: rtl/fibonacci_rsp_fifo.sv
// Circular response FIFO; pointers wrap naturally, count is one bit wider.
// head shows the oldest entry and reads as zero while empty.
module fibonacci_rsp_fifo #(
    parameter int  DEPTH = 8,
    parameter type T     = logic [7:0]
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    output T                       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fibonacci_req_ctrl.sv
// Request-side controller for fibonacci_st: one request in flight, responses queued.
// Optional result checking against FIB_LUT is enabled by defining FIB_CHECK_EN.
//
// state | meaning
// IDLE  | no request in flight; accepts a host request when the FIFO has room
// START | one-cycle start pulse to the engine with the latched term
// WAIT  | waiting for engine valid or for the response timeout
module fibonacci_req_ctrl
    import fibonacci_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int RESP_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [2:0]        req_term,
    output logic              req_ready,
    output logic              start,
    output logic [2:0]        term,
    input  t_output_interface output_interface,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output t_fib_rsp          rsp_data,
    output logic              busy,
    output logic              timeout_err,
    output logic              mismatch_err
);

    localparam int TW = $clog2(RESP_TIMEOUT + 1);
    localparam int CW = $clog2(DEPTH) + 1;

    t_fib_req_state  state;
    logic [TW-1:0]   tmo_cnt;
    logic            tmo_hit;
    logic            run;
    logic            chk;
    logic            fifo_push;
    t_fib_rsp        fifo_push_data;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;

    // run keeps req_ready low until the first edge after reset release
    assign req_ready = run && (state == IDLE) && (fifo_count < CW'(DEPTH));
    assign busy      = (state != IDLE);
    assign rsp_valid = !fifo_empty;
    assign tmo_hit   = (tmo_cnt == TW'(RESP_TIMEOUT - 1));

`ifdef FIB_CHECK_EN
    assign chk = (output_interface.result != FIB_LUT[term]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mismatch_err <= 1'b0;
        end else if (fifo_push && fifo_push_data.mismatch) begin
            mismatch_err <= 1'b1;
        end
    end
`else
    assign chk          = 1'b0;
    assign mismatch_err = 1'b0;
`endif

    // Engine valid wins over a timeout landing in the same cycle
    always_comb begin
        fifo_push      = 1'b0;
        fifo_push_data = '0;
        if (state == START || state == WAIT) begin
            if (output_interface.valid) begin
                fifo_push               = 1'b1;
                fifo_push_data.mismatch = chk;
                fifo_push_data.term     = term;
                fifo_push_data.result   = output_interface.result;
            end else if (state == WAIT && tmo_hit) begin
                fifo_push              = 1'b1;
                fifo_push_data.timeout = 1'b1;
                fifo_push_data.term    = term;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            start       <= 1'b0;
            term        <= '0;
            tmo_cnt     <= '0;
            run         <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            run <= 1'b1;
            case (state)
                IDLE: begin
                    start <= 1'b0;
                    if (req_valid && req_ready) begin
                        state   <= START;
                        start   <= 1'b1;
                        term    <= req_term;
                        tmo_cnt <= '0;
                    end
                end
                START: begin
                    start <= 1'b0;
                    state <= output_interface.valid ? IDLE : WAIT;
                end
                WAIT: begin
                    start <= 1'b0;
                    if (output_interface.valid) begin
                        state <= IDLE;
                    end else if (tmo_hit) begin
                        state       <= IDLE;
                        timeout_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    start <= 1'b0;
                end
            endcase
        end
    end

    fibonacci_rsp_fifo #(
        .DEPTH (DEPTH),
        .T     (t_fib_rsp)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (rsp_ready),
        .head      (rsp_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // A request is only accepted with a free slot, so a push never meets a full FIFO
    push_never_full: assert property (@(posedge clk) disable iff (!rst) !(fifo_push && fifo_full));

endmodule

// File: tb/tb_fibonacci_req_ctrl.sv
// Directed self-checking bench for fibonacci_req_ctrl (DEPTH=8, RESP_TIMEOUT=64).
module tb_fibonacci_req_ctrl;
    import fibonacci_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req_valid = 1'b0;
    logic [2:0]        req_term = '0;
    logic              req_ready;
    logic              start;
    logic [2:0]        term;
    t_output_interface oi = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    t_fib_rsp          rsp_data;
    logic              busy;
    logic              timeout_err;
    logic              mismatch_err;

    int checks = 0;
    int errors = 0;

    localparam logic [7:0] FIB [0:7] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13};
`ifdef FIB_CHECK_EN
    localparam logic EXP_MM = 1'b1;
`else
    localparam logic EXP_MM = 1'b0;
`endif

    fibonacci_req_ctrl #(.DEPTH(8), .RESP_TIMEOUT(64)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_term         (req_term),
        .req_ready        (req_ready),
        .start            (start),
        .term             (term),
        .output_interface (oi),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_data         (rsp_data),
        .busy             (busy),
        .timeout_err      (timeout_err),
        .mismatch_err     (mismatch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for req_ready, then performs one handshake; returns just after edge N.
    task automatic issue(input logic [2:0] t);
        int k = 0;
        while (!req_ready && k < 50) begin
            tick();
            k++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready: req_ready=%b required 1", req_ready);
        end
        req_valid = 1'b1;
        req_term  = t;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b required 0", req_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
        checks++; if (start !== 1'b0 || term !== 3'd0) begin errors++; $display("FAIL rst_start_term: got %b/%0d required 0/0", start, term); end
        checks++; if (rsp_valid !== 1'b0 || rsp_data !== 13'h0) begin errors++; $display("FAIL rst_rsp: got %b/%h required 0/0000", rsp_valid, rsp_data); end
        checks++; if (timeout_err !== 1'b0 || mismatch_err !== 1'b0) begin errors++; $display("FAIL rst_errs: got %b/%b required 0/0", timeout_err, mismatch_err); end
        tick();
        tick();
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_held_ready: got %b required 0", req_ready); end
        rst = 1'b1;
        tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b required 1", req_ready); end
    endtask

    task automatic test_reset_mid_wait();
        issue(3'd5);
        checks++; if (start !== 1'b1 || term !== 3'd5) begin errors++; $display("FAIL rmw_start: got %b/%0d required 1/5", start, term); end
        tick();
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmw_busy_wait: got %b required 1", busy); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || start !== 1'b0) begin errors++; $display("FAIL rmw_async: busy/start %b/%b required 0/0", busy, start); end
        checks++; if (rsp_valid !== 1'b0 || term !== 3'd0 || req_ready !== 1'b0) begin errors++; $display("FAIL rmw_async2: rsp_valid/term/req_ready %b/%0d/%b required 0/0/0", rsp_valid, term, req_ready); end
        @(posedge clk);
        #2;
        rst = 1'b1;
        oi  = '{valid: 1'b1, result: 8'd5};
        tick();
        oi = '0;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmw_late_valid: rsp_valid/busy %b/%b required 0/0", rsp_valid, busy); end
        checks++; if (req_ready !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("FAIL rmw_after: req_ready/timeout_err %b/%b required 1/0", req_ready, timeout_err); end
    endtask

    task automatic test_single();
        t_fib_rsp e;
        int pulses = 0;
        issue(3'd7);
        checks++; if (start !== 1'b1 || term !== 3'd7 || busy !== 1'b1) begin errors++; $display("FAIL single_start: start/term/busy %b/%0d/%b required 1/7/1", start, term, busy); end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (start === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL single_pulse: extra start cycles %0d required 0", pulses); end
        oi = '{valid: 1'b1, result: 8'd13};
        tick();
        oi = '0;
        e = '{timeout: 1'b0, mismatch: 1'b0, term: 3'd7, result: 8'd13};
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== e) begin errors++; $display("FAIL single_rsp: %b/%h required 1/%h", rsp_valid, rsp_data, e); end
        checks++; if (busy !== 1'b0 || term !== 3'd7) begin errors++; $display("FAIL single_after: busy/term %b/%0d required 0/7", busy, term); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_pop: rsp_valid %b required 0", rsp_valid); end
    endtask

    task automatic test_timeout();
        t_fib_rsp e;
        int k = 0;
        issue(3'd3);
        while (!rsp_valid && k < 200) begin
            tick();
            k++;
        end
        checks++; if (k != 65) begin errors++; $display("FAIL tmo_latency: push after %0d edges required 65", k); end
        e = '{timeout: 1'b1, mismatch: 1'b0, term: 3'd3, result: 8'd0};
        checks++; if (rsp_data !== e) begin errors++; $display("FAIL tmo_rsp: %h required %h", rsp_data, e); end
        checks++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL tmo_flags: timeout_err/busy %b/%b required 1/0", timeout_err, busy); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tick();
        checks++; if (timeout_err !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL tmo_sticky: timeout_err/rsp_valid %b/%b required 1/0", timeout_err, rsp_valid); end
    endtask

    // Fill to DEPTH with minimum-latency responses, check back-pressure, drain in order.
    task automatic test_fill_drain(input logic rev);
        t_fib_rsp    e;
        logic [2:0]  t;
        for (int i = 0; i < 8; i++) begin
            t = rev ? 3'(7 - i) : 3'(i);
            issue(t);
            oi = '{valid: 1'b1, result: FIB[t]};
            tick();
            oi = '0;
            if (i < 7) begin
                checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b required 1", i, req_ready); end
            end
        end
        checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b1) begin errors++; $display("FAIL full_ready: req_ready/rsp_valid %b/%b required 0/1", req_ready, rsp_valid); end
        req_valid = 1'b1;
        req_term  = 3'd2;
        tick();
        tick();
        req_valid = 1'b0;
        checks++; if (busy !== 1'b0 || start !== 1'b0) begin errors++; $display("FAIL full_block: busy/start %b/%b required 0/0", busy, start); end
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            t = rev ? 3'(7 - i) : 3'(i);
            e = '{timeout: 1'b0, mismatch: 1'b0, term: t, result: FIB[t]};
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== e) begin errors++; $display("FAIL drain[%0d]: %b/%h required 1/%h", i, rsp_valid, rsp_data, e); end
            tick();
        end
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: rsp_valid %b required 0", rsp_valid); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL pop_empty: rsp_valid %b required 0", rsp_valid); end
    endtask

    // Keep the FIFO at the top end while pushing and popping on the same edge.
    task automatic test_back_to_back();
        t_fib_rsp   exp_q[$];
        t_fib_rsp   e;
        logic [2:0] t;
        int         n = 0;
        for (int i = 0; i < 8; i++) begin
            t = 3'(i);
            issue(t);
            oi = '{valid: 1'b1, result: FIB[t]};
            tick();
            oi = '0;
            exp_q.push_back('{timeout: 1'b0, mismatch: 1'b0, term: t, result: FIB[t]});
        end
        checks++; if (rsp_data !== exp_q[0]) begin errors++; $display("FAIL sim_head0: %h required %h", rsp_data, exp_q[0]); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        void'(exp_q.pop_front());
        for (int j = 0; j < 8; j++) begin
            t = 3'(j) ^ 3'b101;
            issue(t);
            oi = '{valid: 1'b1, result: FIB[t]};
            checks++; if (rsp_data !== exp_q[0]) begin errors++; $display("FAIL sim_head[%0d]: %h required %h", j, rsp_data, exp_q[0]); end
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            oi = '0;
            void'(exp_q.pop_front());
            exp_q.push_back('{timeout: 1'b0, mismatch: 1'b0, term: t, result: FIB[t]});
        end
        rsp_ready = 1'b1;
        while (rsp_valid && n < 20) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 13'h1fff;
            checks++; if (rsp_data !== e) begin errors++; $display("FAIL sim_drain[%0d]: %h required %h", n, rsp_data, e); end
            tick();
            n++;
        end
        rsp_ready = 1'b0;
        checks++; if (n != 7 || exp_q.size() != 0) begin errors++; $display("FAIL sim_count: drained %0d required 7 (left %0d)", n, exp_q.size()); end
    endtask

    task automatic test_mismatch();
        t_fib_rsp e;
        issue(3'd6);
        oi = '{valid: 1'b1, result: 8'd20};
        tick();
        oi = '0;
        e = '{timeout: 1'b0, mismatch: EXP_MM, term: 3'd6, result: 8'd20};
        checks++; if (rsp_data !== e) begin errors++; $display("FAIL mm_rsp: %h required %h", rsp_data, e); end
        checks++; if (mismatch_err !== EXP_MM) begin errors++; $display("FAIL mm_err: %b required %b", mismatch_err, EXP_MM); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        issue(3'd4);
        oi = '{valid: 1'b1, result: 8'd3};
        tick();
        oi = '0;
        e = '{timeout: 1'b0, mismatch: 1'b0, term: 3'd4, result: 8'd3};
        checks++; if (rsp_data !== e || mismatch_err !== EXP_MM) begin errors++; $display("FAIL mm_ok_sticky: %h/%b required %h/%b", rsp_data, mismatch_err, e, EXP_MM); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_reset_mid_wait();
        test_single();
        test_timeout();
        test_fill_drain(1'b0);
        test_fill_drain(1'b1);
        test_back_to_back();
        test_mismatch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
